// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit feeder.
package uart_pkg;

  localparam int unsigned DEPTH_DEF       = 16;
  localparam int unsigned ACK_TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy flags.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Pointer and occupancy next-state; full/empty come from the registered flags.
  always_comb begin
    do_push_s = push & ~full_q & ~rst;
    do_pop_s  = pop & ~empty_q & ~rst;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes in a FIFO and hands them one at a time to a UART transmitter
// using a TX_START / TX_BUSY handshake with an acknowledge timeout.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [7:0]               WR_DATA,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     TX_START,
  output logic [7:0]               TX_DATA,
  input  logic                     TX_BUSY,
  input  logic                     CLR_ERR,
  output logic                     OVERFLOW,
  output logic                     ERR_TIMEOUT
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          err_timeout_q, err_timeout_d;
  logic          pop_s;
  logic          timeout_evt_s;
  logic          overflow_evt_s;
  logic [7:0]    fifo_rd_data_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (WR_EN),
    .push_data (WR_DATA),
    .pop       (pop_s),
    .pop_data  (fifo_rd_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (COUNT)
  );

  // Launch FSM: TX_START stays high until the transmitter shows busy or the wait expires.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    pop_s         = 1'b0;
    timeout_evt_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && !TX_BUSY) begin
          pop_s      = 1'b1;
          tx_data_d  = fifo_rd_data_s;
          tx_start_d = 1'b1;
          timer_d    = TW'(0);
          state_d    = ST_WAIT_ACK;
        end else begin
          tx_start_d = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        if (TX_BUSY) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Expiry drops the byte; it was already popped at launch.
          tx_start_d    = 1'b0;
          timeout_evt_s = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags: a new event takes priority over a clear in the same cycle.
  always_comb begin
    overflow_evt_s = WR_EN & fifo_full_s;
    overflow_d     = overflow_evt_s | (overflow_q & ~CLR_ERR);
    err_timeout_d  = timeout_evt_s | (err_timeout_q & ~CLR_ERR);
  end

  // FSM, handshake output and error flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      overflow_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      overflow_q    <= overflow_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign FULL        = fifo_full_s;
  assign EMPTY       = fifo_empty_s;
  assign TX_START    = tx_start_q;
  assign TX_DATA     = tx_data_q;
  assign OVERFLOW    = overflow_q;
  assign ERR_TIMEOUT = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench: a behavioural UART transmitter serialises launched bytes and
// an independent line decoder compares received frames against the expected queue.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int ACK_T = 1023;
  localparam int BIT   = 8;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr_err;
  logic [7:0] wr_data;
  logic       full, empty, tx_start, overflow, err_timeout;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       model_busy = 1'b0;
  logic       tx_line = 1'b1;
  int         busy_mode = 1;   // 0: transmitter model, 1: forced busy, 2: never acknowledges

  int         vectors = 0;
  int         miscompares = 0;
  int         rx_done = 0;
  bit         rx_active = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign tx_busy = (busy_mode == 0) ? model_busy : (busy_mode == 1);

  uart_tx_feeder dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data),
    .FULL(full), .EMPTY(empty), .COUNT(count),
    .TX_START(tx_start), .TX_DATA(tx_data), .TX_BUSY(tx_busy),
    .CLR_ERR(clr_err), .OVERFLOW(overflow), .ERR_TIMEOUT(err_timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; clr_err = 1'b0;
    cyc();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
    cyc();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || rx_active || model_busy) && t < 20000) begin
      cyc();
      t++;
    end
    repeat (4) cyc();
    check("drain_in_time", int'(t < 20000), 1);
  endtask

  // Behavioural transmitter: accepts TX_START when idle, raises busy on the falling edge.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (busy_mode == 0 && tx_start === 1'b1 && !model_busy) begin
        d = tx_data; model_busy = 1'b1; tx_line = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          tx_line = d[i];
          repeat (BIT) @(negedge clk);
        end
        tx_line = 1'b1;
        repeat (BIT) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Line decoder / scoreboard monitor: samples mid-bit and pops the expected byte.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge tx_line);
      rx_active = 1'b1;
      repeat (BIT / 2) @(posedge clk);
      check("start_bit", int'(tx_line), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge clk);
        b[i] = tx_line;
      end
      repeat (BIT) @(posedge clk);
      check("stop_bit", int'(tx_line), 1);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got %0h expected none at %0t", b, $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", int'(b), int'(e));
      end
      rx_done++;
      rx_active = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int launches;
    int pushed;
    int guard;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    repeat (2) cyc();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_start", int'(tx_start), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_tmo", int'(err_timeout), 0);
    @(negedge clk); rst = 1'b0;

    // Launch latency and hold-until-acknowledge.
    busy_mode = 2;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    check("lat_n1_start", int'(tx_start), 0);
    check("lat_n1_count", int'(count), 1);
    @(negedge clk); wr_en = 1'b0;
    cyc();
    check("lat_n2_start", int'(tx_start), 1);
    check("lat_n2_data", int'(tx_data), 8'hA5);
    check("lat_n2_empty", int'(empty), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_start", int'(tx_start), 1);
      check("hold_data", int'(tx_data), 8'hA5);
    end
    @(negedge clk); busy_mode = 1;
    cyc();
    check("ack_start_low", int'(tx_start), 0);
    @(negedge clk); busy_mode = 2;
    repeat (2) cyc();
    check("idle_start", int'(tx_start), 0);
    check("idle_data_kept", int'(tx_data), 8'hA5);

    // Fill, overflow, clear priority, then ordered drain.
    do_reset();
    busy_mode = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(i);
      exp_q.push_back(8'(i));
    end
    cyc();
    check("fill_count", int'(count), 16);
    check("fill_full", int'(full), 1);
    check("fill_ovf", int'(overflow), 0);
    @(negedge clk); wr_data = 8'h11;
    cyc();
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 16);
    @(negedge clk); wr_en = 1'b0; clr_err = 1'b1;
    cyc();
    check("ovf_clear", int'(overflow), 0);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h12;
    cyc();
    check("ovf_set_wins", int'(overflow), 1);
    @(negedge clk); wr_en = 1'b0; clr_err = 1'b0; busy_mode = 0;
    drain();
    check("fill_drained_empty", int'(empty), 1);
    check("fill_drained_count", int'(count), 0);

    // Simultaneous push and pop at occupancy 5.
    do_reset();
    busy_mode = 1;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    check("pp_pre_count", int'(count), 5);
    @(negedge clk); busy_mode = 2; wr_en = 1'b1; wr_data = 8'h77;
    cyc();
    check("pp_count", int'(count), 5);
    check("pp_start", int'(tx_start), 1);
    check("pp_data", int'(tx_data), 8'h40);
    @(negedge clk); wr_en = 1'b0;

    // Acknowledge timeout.
    do_reset();
    busy_mode = 2;
    push(8'h5A);
    cnt = 0;
    guard = 0;
    while (tx_start !== 1'b1 && guard < 10) begin cyc(); guard++; end
    while (tx_start === 1'b1 && cnt < 2000) begin cnt++; cyc(); end
    check("tmo_cycles", cnt, ACK_T);
    check("tmo_flag", int'(err_timeout), 1);
    check("tmo_start", int'(tx_start), 0);
    @(negedge clk); clr_err = 1'b1;
    cyc();
    check("tmo_clear", int'(err_timeout), 0);
    @(negedge clk); clr_err = 1'b0; wr_en = 1'b1; wr_data = 8'h66;
    cyc();
    @(negedge clk); wr_en = 1'b0;
    cyc();
    check("tmo_relaunch", int'(tx_start), 1);
    check("tmo_relaunch_data", int'(tx_data), 8'h66);

    // Reset while the transmitter is still busy.
    do_reset();
    busy_mode = 2;
    push(8'h99);
    cyc();
    @(negedge clk); busy_mode = 1;
    cyc();
    for (int i = 0; i < 3; i++) push(8'(8'hB0 + i));
    check("rb_pre_count", int'(count), 3);
    @(negedge clk); rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    cyc();
    check("rb_count", int'(count), 0);
    check("rb_empty", int'(empty), 1);
    check("rb_start", int'(tx_start), 0);
    check("rb_data", int'(tx_data), 0);
    @(negedge clk); rst = 1'b0; wr_en = 1'b0;
    launches = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = (i < 2);
      wr_data = (i == 0) ? 8'h3C : 8'hC3;
      cyc();
      if (tx_start) launches++;
    end
    check("rb_no_launch", launches, 0);
    check("rb_new_count", int'(count), 2);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(negedge clk); wr_en = 1'b0; busy_mode = 0;
    drain();

    // Randomised traffic through the transmitter model.
    do_reset();
    busy_mode = 0;
    pushed = 0;
    rx_done = 0;
    guard = 0;
    while (pushed < 60 && guard < 30000) begin
      @(negedge clk);
      if ($urandom_range(0, 2) != 0 && (pushed - rx_done) < DEPTH) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      guard++;
    end
    @(negedge clk); wr_en = 1'b0;
    drain();
    check("rand_ovf", int'(overflow), 0);
    check("rand_tmo", int'(err_timeout), 0);
    check("rand_empty", int'(empty), 1);
    check("rand_all_rx", rx_done, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, 2..256.
REQ-002 Parameter ACK_TIMEOUT, default 1023, maximum CLK cycles to wait for TX_BUSY after TX_START is raised.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 WR_EN  in  1  push request, one byte per cycle.
REQ-006 WR_DATA  in  8  byte to push.
REQ-007 FULL  out  1  FIFO holds DEPTH bytes.
REQ-008 EMPTY  out  1  FIFO holds 0 bytes.
REQ-009 COUNT  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-010 TX_START  out  1  launch request to the UART transmitter.
REQ-011 TX_DATA  out  8  byte presented to the UART transmitter.
REQ-012 TX_BUSY  in  1  transmitter busy flag; changes on falling CLK edge.
REQ-013 CLR_ERR  in  1  clears the sticky error flags.
REQ-014 OVERFLOW  out  1  sticky: a push was dropped.
REQ-015 ERR_TIMEOUT  out  1  sticky: the transmitter never acknowledged a launch.

Function
REQ-016 Push: WR_EN=1 with FULL=0 SHALL write WR_DATA at the tail; COUNT, FULL and EMPTY SHALL update on the same edge.
REQ-017 WR_EN=1 with FULL=1 SHALL drop the byte and set OVERFLOW; FULL is the registered value, so a same-cycle pop does not admit the write.
REQ-018 A same-cycle push and pop with 0<COUNT<DEPTH SHALL leave COUNT unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 FSM states: IDLE, WAIT_ACK, WAIT_DONE.
REQ-020 In IDLE with EMPTY=0 and TX_BUSY=0, the FSM SHALL pop the head byte into TX_DATA, set TX_START=1, clear the timeout counter and go to WAIT_ACK.
REQ-021 In WAIT_ACK, TX_START=1 and TX_DATA SHALL be held stable until TX_BUSY=1 is sampled; the FSM SHALL then set TX_START=0 and go to WAIT_DONE.
REQ-022 In WAIT_ACK, when the counter reaches ACK_TIMEOUT without TX_BUSY=1, the FSM SHALL set TX_START=0 and ERR_TIMEOUT=1, drop the byte and go to IDLE.
REQ-023 In WAIT_DONE with TX_BUSY=0 sampled, the FSM SHALL go to IDLE; the next launch may occur on the following edge.
REQ-024 Latency: a byte pushed in cycle N into an empty FIFO with the FSM idle SHALL show TX_START=1 from cycle N+2.
REQ-025 TX_DATA SHALL keep the last launched byte while idle; it is not cleared after transmission.
REQ-026 CLR_ERR=1 SHALL clear OVERFLOW and ERR_TIMEOUT; if an error event occurs in the same cycle, the set SHALL win.
REQ-027 The FIFO storage SHALL not be readable by any path other than the FSM pop.

Reset
REQ-028 RST=1 SHALL force the following on the next edge:
- pointers=0, COUNT=0, EMPTY=1, FULL=0
- TX_START=0, TX_DATA=8'h00
- OVERFLOW=0, ERR_TIMEOUT=0
- state=IDLE, timeout counter=0
REQ-029 Reset during WAIT_ACK or WAIT_DONE SHALL discard FIFO contents and drop TX_START immediately.
- The transmitter has no reset and may still be sending.
- After reset, no launch SHALL occur until TX_BUSY=0 is sampled in IDLE.
REQ-030 While RST=1, WR_EN SHALL be ignored.

Structure
REQ-031 Shared package uart_pkg SHALL hold:
- the FSM state typedef
- DEPTH and ACK_TIMEOUT default constants
REQ-032 The FIFO SHALL be a sub-module byte_fifo with synchronous reset and push/pop/full/empty/count ports; uart_tx_feeder holds the FSM, timeout counter and error flags.

Verification
REQ-033 Push 8'hA5 into an empty FIFO with TX_BUSY=0 -> TX_START=1 and TX_DATA=8'hA5 at cycle N+2; TX_START held until TX_BUSY=1; EMPTY=1 after the pop.
REQ-034 Push 8'h01..8'h10 (16 bytes), then one more push -> FULL=1, OVERFLOW=1; the 17th byte is never transmitted; output order is 01..10.
REQ-035 With COUNT=5, drive WR_EN=1 for one cycle coinciding with a pop -> COUNT stays 5; pointers wrap correctly after more than 16 total pushes.
REQ-036 Hold TX_BUSY=0 after a launch -> TX_START falls and ERR_TIMEOUT=1 at cycle 1023 of WAIT_ACK; FSM returns to IDLE; CLR_ERR clears the flag.
REQ-037 Assert RST in WAIT_DONE with TX_BUSY=1 held for 20 cycles -> COUNT=0, TX_START=0; after new pushes, no launch occurs until TX_BUSY=0.
REQ-038 Connect the feeder to the transmitter at 100 MHz and push "HELLO" -> the serial line carries 5 frames (start bit, 8 data bits LSB first, stop bit) in order, with no duplicated or dropped bytes.
